op_amp_out_monitor: RTL and testbench
=====================================

Name: op_amp_out_monitor

Overview:
- Reader-side companion to the op-amp model. It consumes the op-amp output sample stream, which feeds pin6 into this block's sample_in.
- Gathers windowed statistics: min, max, arithmetic mean, and saturation hits against the live supply rails.
- Presents each completed window through a valid/ready result handshake.
- Sits in the analog-model test harness and in system blocks that need an output-health monitor.

Parameters:
- WIDTH, 16, sample and rail width, signed two's complement.
- WIN_LOG2, 4, window length is 2**WIN_LOG2 samples; legal range 1..8.
- SAT_MARGIN, 0, non-negative guard band in LSBs; a sample within this distance of a rail counts as saturated.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  sample_in is valid this cycle.
- sample_in  in  WIDTH signed  op-amp output sample.
- vcc  in  WIDTH signed  positive rail, sampled together with each accepted sample.
- vee  in  WIDTH signed  negative rail, sampled together with each accepted sample.
- clear  in  1  synchronous flush of window, results and overrun.
- result_valid  out  1  window result available.
- result_ready  in  1  consumer accepts result.
- min_out  out  WIDTH signed  minimum sample in the window.
- max_out  out  WIDTH signed  maximum sample in the window.
- avg_out  out  WIDTH signed  window mean.
- sat_hi_count  out  WIN_LOG2+1  count of samples >= vcc-SAT_MARGIN.
- sat_lo_count  out  WIN_LOG2+1  count of samples <= vee+SAT_MARGIN.
- overrun  out  1  sticky flag: a window result was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Accumulator, sample counter and running min/max are cleared.
  - Applies mid-window too: partial window data is discarded.
- The FSM has two states: IDLE and ACCUM.
  - IDLE: on sample_en, load running min = max = acc = sample_in, set count = 1 and per-sample saturation flags, then go to ACCUM.
  - ACCUM: on each sample_en, acc += sample_in, min/max update with signed compare, sat counters increment, count++.
- Window completion happens on the cycle the 2**WIN_LOG2-th sample is accepted.
  - Results latch into the output registers at that clock edge, so result_valid rises the following cycle: 1-cycle latency from the last sample.
  - The latched results include the last sample.
  - The FSM returns to IDLE that same edge, so there are no dead cycles and the next sample_en starts a new window.
- Arithmetic:
  - Accumulator is signed WIDTH+WIN_LOG2 bits and cannot overflow.
  - avg_out = acc >>> WIN_LOG2, an arithmetic shift that floors toward -inf, truncated to WIDTH bits.
  - Saturation thresholds are computed in WIDTH+1 bits so that vcc-SAT_MARGIN and vee+SAT_MARGIN cannot wrap.
  - A sample meeting both thresholds (vcc <= vee misconfiguration) increments both counters.
- Result handshake:
  - A transfer occurs when result_valid && result_ready.
  - result_valid stays high and all result outputs are stable until the transfer.
  - After a transfer with no new window completing, result_valid drops the next cycle; result data holds its last value.
- Window completes while result_valid=1:
  - If result_ready=1 that cycle, the new result loads, result_valid stays 1, and no overrun is flagged.
  - If result_ready=0, the new result is dropped, the old result is retained, and overrun is set to 1 (sticky).
- clear (synchronous):
  - Has highest priority below reset.
  - Returns the FSM to IDLE, discards the partial window, and clears result_valid and overrun.
  - Result data registers are zeroed.
  - A sample_en in the same cycle is ignored.
  - A window that would complete that cycle is discarded.
- sample_en=0 in ACCUM holds all state; there is no timeout.
- The unused op-amp pins (offset null, nc) are not inputs to this block.

Test Plan:
- WIDTH=16, WIN_LOG2=4, SAT_MARGIN=0, vcc=1000, vee=-1000, 16 samples of 100 -> one cycle after the 16th: result_valid=1, min=max=avg=100, sat counts 0.
- Ramp -8..7 with gaps in sample_en -> min=-8, max=7, sum=-8 so avg=-1 (floor), sat counts 0.
- 4x 1000, 3x -1000, 9x 0 -> sat_hi_count=4, sat_lo_count=3, min=-1000, max=1000, avg=62 (sum 1000 >>> 4).
- result_ready=0 for two full windows (first constant 5, second constant 9) -> outputs hold 5, overrun=1. Then ready=1 -> transfer, valid drops, overrun stays 1 until clear.
- 7 samples, then rst_n pulse low mid-cycle -> outputs 0 immediately (asynchronous). Afterwards 15 samples -> no result; the 16th yields a result.
- clear asserted with sample_en on the 16th sample of a window -> no result_valid, next window requires 16 fresh samples. Also ready=1 exactly at back-to-back completion -> valid continuous, no overrun.

Source files
------------

// File: rtl/op_amp_out_monitor.sv
// Windowed output-health monitor for the op-amp sample stream: min, max, mean
// and rail-saturation counts over 2**WIN_LOG2 samples, with a valid/ready result port.
module op_amp_out_monitor #(
  parameter int WIDTH      = 16,
  parameter int WIN_LOG2   = 4,
  parameter int SAT_MARGIN = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic signed [WIDTH-1:0] vcc,
  input  logic signed [WIDTH-1:0] vee,
  input  logic                    clear,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic signed [WIDTH-1:0] min_out,
  output logic signed [WIDTH-1:0] max_out,
  output logic signed [WIDTH-1:0] avg_out,
  output logic [WIN_LOG2:0]       sat_hi_count,
  output logic [WIN_LOG2:0]       sat_lo_count,
  output logic                    overrun
);

  localparam int ACC_W = WIDTH + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1 << WIN_LOG2);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [WIDTH-1:0] run_min, run_max, min_nxt, max_nxt, avg_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt, hi_cnt, hi_nxt, lo_cnt, lo_nxt;
  logic signed [WIDTH:0]   smp_x, hi_thr, lo_thr;
  logic                    is_hi, is_lo, win_done;

  // One extra bit keeps the guard-banded rail thresholds from wrapping.
  assign smp_x  = (WIDTH+1)'(sample_in);
  assign hi_thr = (WIDTH+1)'(vcc) - (WIDTH+1)'(SAT_MARGIN);
  assign lo_thr = (WIDTH+1)'(vee) + (WIDTH+1)'(SAT_MARGIN);
  assign is_hi  = (smp_x >= hi_thr);
  assign is_lo  = (smp_x <= lo_thr);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    min_nxt   = run_min;
    max_nxt   = run_max;
    cnt_nxt   = cnt;
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    win_done  = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          acc_nxt   = ACC_W'(sample_in);
          min_nxt   = sample_in;
          max_nxt   = sample_in;
          cnt_nxt   = CNT_W'(1);
          hi_nxt    = CNT_W'(is_hi);
          lo_nxt    = CNT_W'(is_lo);
          state_nxt = ACCUM;
        end
        ACCUM: begin
          acc_nxt = acc + ACC_W'(sample_in);
          if (sample_in < run_min) min_nxt = sample_in;
          if (sample_in > run_max) max_nxt = sample_in;
          cnt_nxt = cnt + 1'b1;
          hi_nxt  = hi_cnt + CNT_W'(is_hi);
          lo_nxt  = lo_cnt + CNT_W'(is_lo);
          if (cnt_nxt == WIN_LEN) begin
            win_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  // Mean floors toward -inf via the arithmetic shift, then truncates to WIDTH.
  assign avg_nxt = WIDTH'(acc_nxt >>> WIN_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      run_min <= '0;
      run_max <= '0;
      cnt     <= '0;
      hi_cnt  <= '0;
      lo_cnt  <= '0;
    end else if (clear) begin
      acc     <= '0;
      run_min <= '0;
      run_max <= '0;
      cnt     <= '0;
      hi_cnt  <= '0;
      lo_cnt  <= '0;
    end else begin
      acc     <= acc_nxt;
      run_min <= min_nxt;
      run_max <= max_nxt;
      cnt     <= cnt_nxt;
      hi_cnt  <= hi_nxt;
      lo_cnt  <= lo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      min_out      <= '0;
      max_out      <= '0;
      avg_out      <= '0;
      sat_hi_count <= '0;
      sat_lo_count <= '0;
    end else if (clear) begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      min_out      <= '0;
      max_out      <= '0;
      avg_out      <= '0;
      sat_hi_count <= '0;
      sat_lo_count <= '0;
    end else if (win_done && (!result_valid || result_ready)) begin
      result_valid <= 1'b1;
      min_out      <= min_nxt;
      max_out      <= max_nxt;
      avg_out      <= avg_nxt;
      sat_hi_count <= hi_nxt;
      sat_lo_count <= lo_nxt;
    end else if (win_done) begin
      // Consumer still holds the previous result: drop the new one.
      overrun <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_op_amp_out_monitor.sv
// Directed bench for op_amp_out_monitor: table of full windows plus
// hand sequences for overrun, async reset, clear and back-to-back results.
module tb_op_amp_out_monitor;

  logic               clk, rst_n, sample_en, clear, result_ready;
  logic signed [15:0] sample_in, vcc, vee;
  logic signed [15:0] min_out, max_out, avg_out;
  logic [4:0]         sat_hi_count, sat_lo_count;
  logic               result_valid, overrun;
  int                 checks, errors;

  typedef logic [15:0][15:0] win_t;
  typedef struct {
    win_t               smp;
    int                 gap;
    logic signed [15:0] rail_hi;
    logic signed [15:0] rail_lo;
    int                 emin, emax, eavg, ehi, elo;
  } vec_t;

  vec_t tbl[6];

  op_amp_out_monitor #(.WIDTH(16), .WIN_LOG2(4), .SAT_MARGIN(0)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sample_in(sample_in),
    .vcc(vcc), .vee(vee), .clear(clear), .result_valid(result_valid),
    .result_ready(result_ready), .min_out(min_out), .max_out(max_out),
    .avg_out(avg_out), .sat_hi_count(sat_hi_count), .sat_lo_count(sat_lo_count),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int v, input int mn, input int mx,
                         input int av, input int hi, input int lo, input int ov);
    chk({tag, " valid"}, int'(result_valid), v);
    chk({tag, " min"}, int'(min_out), mn);
    chk({tag, " max"}, int'(max_out), mx);
    chk({tag, " avg"}, int'(avg_out), av);
    chk({tag, " sat_hi"}, int'(sat_hi_count), hi);
    chk({tag, " sat_lo"}, int'(sat_lo_count), lo);
    chk({tag, " overrun"}, int'(overrun), ov);
  endtask

  // Inputs change on the falling edge; returns on the next falling edge.
  task automatic step(input logic en, input logic signed [15:0] s);
    sample_en = en;
    sample_in = s;
    @(negedge clk);
  endtask

  task automatic feed_const(input logic signed [15:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b1, s);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    step(1'b0, 16'sd0);
    result_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // 16x 100
    for (int i = 0; i < 16; i++) tbl[0].smp[i] = 16'd100;
    tbl[0].gap = 0; tbl[0].rail_hi = 16'sd1000; tbl[0].rail_lo = -16'sd1000;
    tbl[0].emin = 100; tbl[0].emax = 100; tbl[0].eavg = 100; tbl[0].ehi = 0; tbl[0].elo = 0;
    // ramp -8..7 with idle gaps, sum -8 floors to -1
    for (int i = 0; i < 16; i++) tbl[1].smp[i] = 16'(i - 8);
    tbl[1].gap = 1; tbl[1].rail_hi = 16'sd1000; tbl[1].rail_lo = -16'sd1000;
    tbl[1].emin = -8; tbl[1].emax = 7; tbl[1].eavg = -1; tbl[1].ehi = 0; tbl[1].elo = 0;
    // 4x rail-high, 3x rail-low, 9x 0, sum 1000
    for (int i = 0; i < 16; i++) tbl[2].smp[i] = (i < 4) ? 16'd1000 : (i < 7) ? 16'(-1000) : 16'd0;
    tbl[2].gap = 2; tbl[2].rail_hi = 16'sd1000; tbl[2].rail_lo = -16'sd1000;
    tbl[2].emin = -1000; tbl[2].emax = 1000; tbl[2].eavg = 62; tbl[2].ehi = 4; tbl[2].elo = 3;
    // one LSB inside each rail: not saturated
    for (int i = 0; i < 16; i++) tbl[3].smp[i] = (i < 8) ? 16'd999 : 16'(-999);
    tbl[3].gap = 0; tbl[3].rail_hi = 16'sd1000; tbl[3].rail_lo = -16'sd1000;
    tbl[3].emin = -999; tbl[3].emax = 999; tbl[3].eavg = 0; tbl[3].ehi = 0; tbl[3].elo = 0;
    // sum -7 floors to -1
    for (int i = 0; i < 16; i++) tbl[4].smp[i] = (i == 5) ? 16'(-7) : 16'd0;
    tbl[4].gap = 0; tbl[4].rail_hi = 16'sd1000; tbl[4].rail_lo = -16'sd1000;
    tbl[4].emin = -7; tbl[4].emax = 0; tbl[4].eavg = -1; tbl[4].ehi = 0; tbl[4].elo = 0;
    // vcc == vee == 0: every sample hits both thresholds, counters reach 16
    for (int i = 0; i < 16; i++) tbl[5].smp[i] = 16'd0;
    tbl[5].gap = 0; tbl[5].rail_hi = 16'sd0; tbl[5].rail_lo = 16'sd0;
    tbl[5].emin = 0; tbl[5].emax = 0; tbl[5].eavg = 0; tbl[5].ehi = 16; tbl[5].elo = 16;

    rst_n = 1'b1; sample_en = 1'b0; sample_in = '0; clear = 1'b0; result_ready = 1'b0;
    vcc = 16'sd1000; vee = -16'sd1000;
    #1 rst_n = 1'b0;
    #1 chk_res("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      vcc = tbl[t].rail_hi;
      vee = tbl[t].rail_lo;
      for (int i = 0; i < 16; i++) begin
        step(1'b1, $signed(tbl[t].smp[i]));
        if (i < 15) for (int g = 0; g < tbl[t].gap; g++) step(1'b0, 16'sd0);
      end
      chk_res($sformatf("win%0d", t), 1, tbl[t].emin, tbl[t].emax, tbl[t].eavg,
              tbl[t].ehi, tbl[t].elo, 0);
      consume();
      chk($sformatf("win%0d drop valid", t), int'(result_valid), 0);
      chk($sformatf("win%0d hold min", t), int'(min_out), tbl[t].emin);
    end
    vcc = 16'sd1000; vee = -16'sd1000;

    // Overrun: two windows without ready
    feed_const(16'sd5, 16);
    chk_res("ovr first", 1, 5, 5, 5, 0, 0, 0);
    feed_const(16'sd9, 16);
    chk_res("ovr dropped", 1, 5, 5, 5, 0, 0, 1);
    consume();
    chk_res("ovr after xfer", 0, 5, 5, 5, 0, 0, 1);
    clear = 1'b1;
    step(1'b0, 16'sd0);
    clear = 1'b0;
    chk_res("ovr cleared", 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-window
    feed_const(16'sd7, 16);
    chk_res("pre reset", 1, 7, 7, 7, 0, 0, 0);
    feed_const(16'sd50, 7);
    sample_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_res("async reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed_const(16'sd3, 15);
    chk("reset 15 samples valid", int'(result_valid), 0);
    feed_const(16'sd3, 1);
    chk_res("reset 16th", 1, 3, 3, 3, 0, 0, 0);
    consume();

    // clear on the completing sample discards the window
    feed_const(16'sd4, 15);
    clear = 1'b1;
    step(1'b1, 16'sd4);
    clear = 1'b0;
    chk("clear on 16th valid", int'(result_valid), 0);
    feed_const(16'sd6, 15);
    chk("clear then 15 valid", int'(result_valid), 0);
    feed_const(16'sd6, 1);
    chk_res("clear then 16", 1, 6, 6, 6, 0, 0, 0);
    consume();

    // Back-to-back: ready exactly at the completing edge
    feed_const(16'sd11, 16);
    chk_res("b2b first", 1, 11, 11, 11, 0, 0, 0);
    feed_const(16'sd12, 15);
    chk("b2b valid held", int'(result_valid), 1);
    result_ready = 1'b1;
    step(1'b1, 16'sd12);
    result_ready = 1'b0;
    chk_res("b2b second", 1, 12, 12, 12, 0, 0, 0);
    consume();
    chk("b2b drop valid", int'(result_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
